link_test_ctrl: RTL

//  Sequencer and BER monitor for the QAM link chain (M-seq -> conv -> QAM -> channel -> demod -> decoder).

---
 rtl/link_ctrl_pkg.sv | 31 +++
 rtl/link_test_ctrl_if.sv | 35 +++
 rtl/ber_delay_line.sv | 29 ++
 rtl/link_test_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/link_ctrl_pkg.sv
// Shared definitions for the link test controller: state encoding, defaults, saturating increment.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package link_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    FLUSH   = 3'd2,
    SYNC    = 3'd3,
    MEASURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int INIT_CYC_DEF   = 4;
  localparam int FLUSH_BITS_DEF = 64;
  localparam int MAX_DLY_DEF    = 31;
  localparam int DLY_W_DEF      = 5;
  localparam int SYNC_LEN_DEF   = 32;
  localparam int MEAS_BITS_DEF  = 4096;
  localparam int CNT_W_DEF      = 16;
  localparam int ERR_PERIOD_DEF = 256;

  // Increment v, sticking at the all-ones value of a w-bit counter (w < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/link_test_ctrl_if.sv
// Control, bit-stream and result signals between the link test controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; bit_stb is a one-cycle strobe the controller must accept.
interface link_test_ctrl_if
  import link_ctrl_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic             bit_stb;
  logic             ref_bit;
  logic             dec_bit;
  logic             init_tab;
  logic             tx_en;
  logic             has_error;
  logic             busy;
  logic             locked;
  logic             done;
  logic             fail;
  logic [DLY_W-1:0] lock_dly;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, abort, bit_stb, ref_bit, dec_bit,
    input  init_tab, tx_en, has_error, busy, locked, done, fail, lock_dly, bit_cnt, err_cnt
  );

  modport slave (
    input  start, abort, bit_stb, ref_bit, dec_bit,
    output init_tab, tx_en, has_error, busy, locked, done, fail, lock_dly, bit_cnt, err_cnt
  );
endinterface

// File: rtl/ber_delay_line.sv
// Reference delay line: MAX_DLY+1-bit window of ref_bit (live bit plus MAX_DLY stored), tap mux by sel.
// Latency: tap is combinational; tap[0] is the live ref_bit, tap[d] the bit d strobes earlier.
// Backpressure: none; shifts on every bit_stb regardless of controller state.
module ber_delay_line #(
  parameter int MAX_DLY = 31,
  parameter int DLY_W   = 5
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             bit_stb,
  input  logic             ref_bit,
  input  logic [DLY_W-1:0] sel,
  output logic             tap
);
  logic [MAX_DLY-1:0] hist_q;
  logic [MAX_DLY:0]   win;

  assign win = {hist_q, ref_bit};
  assign tap = win[sel];

  // Shift the newest reference bit in on each strobe; history is cleared only by reset.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else if (bit_stb) begin
      hist_q <= win[MAX_DLY-1:0];
    end
  end
endmodule

// File: rtl/link_test_ctrl.sv
// Link test sequencer + BER monitor: init pulse, channel enable, flush, delay search, error count.
// Latency: all outputs registered, one cycle after the qualifying start/strobe/abort.
// Backpressure: none; optional has_error injection built only when LINK_ERR_INJ_EN is defined.
module link_test_ctrl
  import link_ctrl_pkg::*;
#(
  parameter int INIT_CYC   = INIT_CYC_DEF,
  parameter int FLUSH_BITS = FLUSH_BITS_DEF,
  parameter int MAX_DLY    = MAX_DLY_DEF,
  parameter int DLY_W      = DLY_W_DEF,
  parameter int SYNC_LEN   = SYNC_LEN_DEF,
  parameter int MEAS_BITS  = MEAS_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
`ifdef LINK_ERR_INJ_EN
  ,
  parameter int ERR_PERIOD = ERR_PERIOD_DEF
`endif
) (
  input logic             sys_clk,
  input logic             reset,
  link_test_ctrl_if.slave lnk
);
  // One sequencing counter serves INIT cycles, FLUSH strobes, SYNC run length and MEASURE bits.
  localparam int SEQ_W = 16;

  state_t           state_q;
  logic [SEQ_W-1:0] cnt_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] lock_dly_q;
  logic [DLY_W-1:0] sel;
  logic             init_tab_q, tx_en_q, busy_q, locked_q, done_q, fail_q;
  logic [CNT_W-1:0] bit_cnt_q, err_cnt_q;
  logic             tap;
  logic             mismatch;

  assign sel      = (state_q == MEASURE) ? lock_dly_q : dly_q;
  assign mismatch = lnk.dec_bit ^ tap;

  ber_delay_line #(
    .MAX_DLY (MAX_DLY),
    .DLY_W   (DLY_W)
  ) u_dly (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bit_stb (lnk.bit_stb),
    .ref_bit (lnk.ref_bit),
    .sel     (sel),
    .tap     (tap)
  );

  // Sequencer FSM; every status output is a register written alongside the state.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dly_q      <= '0;
      lock_dly_q <= '0;
      init_tab_q <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else if (lnk.abort) begin
      // abort beats everything, including a simultaneous start
      state_q    <= IDLE;
      cnt_q      <= '0;
      dly_q      <= '0;
      lock_dly_q <= '0;
      init_tab_q <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (lnk.start) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            dly_q      <= '0;
            lock_dly_q <= '0;
            init_tab_q <= 1'b1;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b1;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
          end
        end
        INIT: begin
          // strobes are ignored here; only the delay line keeps shifting
          if (cnt_q == SEQ_W'(INIT_CYC - 1)) begin
            state_q    <= FLUSH;
            cnt_q      <= '0;
            init_tab_q <= 1'b0;
            tx_en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FLUSH: begin
          if (lnk.bit_stb) begin
            if (cnt_q == SEQ_W'(FLUSH_BITS - 1)) begin
              state_q <= SYNC;
              cnt_q   <= '0;
              dly_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SYNC: begin
          if (lnk.bit_stb) begin
            if (!mismatch) begin
              if (cnt_q == SEQ_W'(SYNC_LEN - 1)) begin
                state_q    <= MEASURE;
                cnt_q      <= '0;
                locked_q   <= 1'b1;
                lock_dly_q <= dly_q;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              cnt_q <= '0;
              // the search walks upward only; running out of delays is a failed sync
              if (dly_q == DLY_W'(MAX_DLY)) begin
                state_q <= DONE;
                fail_q  <= 1'b1;
                done_q  <= 1'b1;
                tx_en_q <= 1'b0;
                busy_q  <= 1'b0;
              end else begin
                dly_q <= dly_q + 1'b1;
              end
            end
          end
        end
        MEASURE: begin
          if (lnk.bit_stb) begin
            bit_cnt_q <= CNT_W'(sat_inc(32'(bit_cnt_q), CNT_W));
            if (mismatch) begin
              err_cnt_q <= CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
            end
            // the final strobe is counted and the window closes on the same edge
            if (cnt_q == SEQ_W'(MEAS_BITS - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              tx_en_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LINK_ERR_INJ_EN
  logic has_error_q;

  // One-cycle injection request whenever the measured bit count lands on a multiple of ERR_PERIOD.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      has_error_q <= 1'b0;
    end else begin
      has_error_q <= !lnk.abort && (state_q == MEASURE) && lnk.bit_stb &&
                     (((int'(cnt_q) + 1) % ERR_PERIOD) == 0);
    end
  end

  assign lnk.has_error = has_error_q;
`else
  assign lnk.has_error = 1'b0;
`endif

  assign lnk.init_tab = init_tab_q;
  assign lnk.tx_en    = tx_en_q;
  assign lnk.busy     = busy_q;
  assign lnk.locked   = locked_q;
  assign lnk.done     = done_q;
  assign lnk.fail     = fail_q;
  assign lnk.lock_dly = lock_dly_q;
  assign lnk.bit_cnt  = bit_cnt_q;
  assign lnk.err_cnt  = err_cnt_q;
endmodule
